axil_reg_slave: RTL
===================

Name: axil_reg_slave

Overview:
- AXI4-Lite slave register bank; terminates the master-side AXI-Lite channel driven by axil_passthru and exposes control/status registers to fabric logic.
- Reg 0: read-only ID constant. Reg 1: read-only free-running cycle counter. Regs 2..C_NUM_REGS-1: read/write control registers with byte strobes.
- Each RW register drives a flat output bus and a one-cycle write pulse.

Parameters:
- C_S_AXI_DATA_WIDTH, 32, data width; only 32 is supported.
- C_S_AXI_ADDR_WIDTH, 7, byte address width; register index = ADDR[C_S_AXI_ADDR_WIDTH-1:2].
- C_NUM_REGS, 16, number of implemented registers; legal range 3..2^(C_S_AXI_ADDR_WIDTH-2).
- C_ID_VALUE, 32'hA5A5_0001, constant returned by reg 0.

Ports:
- S_AXI_ACLK  in  1  clock
- S_AXI_ARESET  in  1  reset, asynchronous, active-high
- S_AXI_AWADDR  in  C_S_AXI_ADDR_WIDTH  write address
- S_AXI_AWPROT  in  3  ignored
- S_AXI_AWVALID  in  1 / S_AXI_AWREADY  out  1
- S_AXI_WDATA  in  32 / S_AXI_WSTRB  in  4 / S_AXI_WVALID  in  1 / S_AXI_WREADY  out  1
- S_AXI_BRESP  out  2 / S_AXI_BVALID  out  1 / S_AXI_BREADY  in  1
- S_AXI_ARADDR  in  C_S_AXI_ADDR_WIDTH / S_AXI_ARPROT  in  3 (ignored) / S_AXI_ARVALID  in  1 / S_AXI_ARREADY  out  1
- S_AXI_RDATA  out  32 / S_AXI_RRESP  out  2 / S_AXI_RVALID  out  1 / S_AXI_RREADY  in  1
- reg_out  out  32*C_NUM_REGS  flat register contents; slice i = reg i (slices 0/1 mirror ID and counter)
- reg_wr_pulse  out  C_NUM_REGS  bit i high for one cycle after a committed write to RW reg i

Behaviour:
- Reset (async assert, sync release to S_AXI_ACLK): all ready/valid outputs 0, BRESP/RRESP 0, RDATA 0, RW regs 0, counter 0, reg_wr_pulse 0.
- Counter: increments by 1 every cycle out of reset; wraps 0xFFFFFFFF -> 0.
- Write path:
  - AW and W are captured independently into holding registers.
  - AWREADY = !aw_held && !BVALID; WREADY = !w_held && !BVALID. Both ready signals deassert while the respective channel is held.
  - AW-before-W, W-before-AW and same-cycle arrival are all legal.
  - Commit occurs in the cycle both are held and BVALID=0. The target register updates byte-wise per WSTRB at the commit edge; BVALID=1 on the next cycle; holding registers are cleared.
  - BVALID holds until BREADY. Ready re-asserts the cycle after the B handshake, giving a minimum 3 cycles per write.
  - Writes to reg 0/1 or to index >= C_NUM_REGS: no state change, no pulse, BRESP=OKAY.
- Read path:
  - ARREADY = !RVALID.
  - On AR handshake, RDATA is latched from the register value as of that cycle, before any same-edge write commit. RVALID=1 next cycle and holds until RREADY.
  - Out-of-range index reads 0, RRESP=OKAY.
  - Read and write channels are fully independent; a simultaneous read and write to the same register returns the old value.
- Address low bits [1:0] are ignored (unaligned access aliases down).
- RDATA/RRESP remain stable while RVALID=1 && !RREADY; BRESP likewise while BVALID=1.
- Reset mid-transaction drops all pending handshakes and held data; no partial write is applied.

Optional Feature:
- Macro: AXIL_REG_SLVERR_EN.
- Defined: writes to reg 0/1 or out-of-range indices return BRESP=2'b10 (SLVERR); out-of-range reads return RRESP=2'b10 with RDATA=0. In-range reads of reg 0/1 remain OKAY.
- Undefined: all responses OKAY, as in Behaviour.

Test Plan:
- Reset then read addr 0x00 -> RDATA=0xA5A50001, RRESP=0; read 0x04 twice 10 cycles apart -> second value minus first equals 10 + handshake-cycle difference.
- Write 0x08 data 0x12345678 strb 0xF with AW 3 cycles before W -> BVALID 1 cycle after W accepted; reg_out[95:64]=0x12345678; reg_wr_pulse[2] pulses once.
- Write 0x0C data 0xFFFFFFFF strb 0x5 after reset, W first with BREADY held low 4 cycles -> reg 3=0x00FF00FF; BVALID stays high, AWREADY/WREADY low until B handshake.
- Same-cycle AR and commit to reg 2 (old 0x1, new 0x2) -> read returns 0x1; subsequent read returns 0x2.
- Write 0x7C with C_NUM_REGS=16 -> no reg change, BRESP=0 (SLVERR 2'b10 with AXIL_REG_SLVERR_EN); read 0x7C -> RDATA=0, RRESP per macro.
- Assert S_AXI_ARESET while AW held and W not yet sent -> after release, AWREADY=1, no write ever commits, all RW regs 0.

Source files
------------

// File: rtl/axil_reg_slave.sv
// AXI4-Lite register bank: reg 0 = ID, reg 1 = free-running counter, regs 2..N-1 = RW control.
// Optional macro AXIL_REG_SLVERR_EN: SLVERR on illegal writes and out-of-range reads.
module axil_reg_slave #(
  parameter int          C_S_AXI_DATA_WIDTH = 32,
  parameter int          C_S_AXI_ADDR_WIDTH = 7,
  parameter int          C_NUM_REGS         = 16,
  parameter logic [31:0] C_ID_VALUE         = 32'hA5A5_0001
) (
  input  logic                                 S_AXI_ACLK,
  input  logic                                 S_AXI_ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]        S_AXI_AWADDR,
  input  logic [2:0]                           S_AXI_AWPROT,
  input  logic                                 S_AXI_AWVALID,
  output logic                                 S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]        S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]      S_AXI_WSTRB,
  input  logic                                 S_AXI_WVALID,
  output logic                                 S_AXI_WREADY,
  output logic [1:0]                           S_AXI_BRESP,
  output logic                                 S_AXI_BVALID,
  input  logic                                 S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]        S_AXI_ARADDR,
  input  logic [2:0]                           S_AXI_ARPROT,
  input  logic                                 S_AXI_ARVALID,
  output logic                                 S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]        S_AXI_RDATA,
  output logic [1:0]                           S_AXI_RRESP,
  output logic                                 S_AXI_RVALID,
  input  logic                                 S_AXI_RREADY,
  output logic [C_S_AXI_DATA_WIDTH*C_NUM_REGS-1:0] reg_out,
  output logic [C_NUM_REGS-1:0]                reg_wr_pulse
);
  localparam int DW = C_S_AXI_DATA_WIDTH;
  localparam int IW = C_S_AXI_ADDR_WIDTH - 2;
  localparam int SW = DW / 8;

  logic                         ready_en;
  logic [DW-1:0]                cnt;
  logic                         aw_held, w_held;
  logic [IW-1:0]                aw_idx_q;
  logic [DW-1:0]                w_data_q;
  logic [SW-1:0]                w_strb_q;
  logic                         bvalid, rvalid;
  logic [1:0]                   bresp, rresp;
  logic [DW-1:0]                rdata;
  logic [C_NUM_REGS-1:0][DW-1:0] regs_all;
  logic [C_NUM_REGS-1:0]        wr_hit;
  logic                         wr_ok, rd_in;
  logic [DW-1:0]                rd_val;
  logic [IW-1:0]                ar_idx;
  logic                         aw_hs, w_hs, ar_hs, commit;
  logic                         unused_ok;

  assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  // Readies stay low through reset and the first cycle after release.
  assign S_AXI_AWREADY = ready_en && !aw_held && !bvalid;
  assign S_AXI_WREADY  = ready_en && !w_held && !bvalid;
  assign S_AXI_ARREADY = ready_en && !rvalid;
  assign S_AXI_BVALID  = bvalid;
  assign S_AXI_BRESP   = bresp;
  assign S_AXI_RVALID  = rvalid;
  assign S_AXI_RRESP   = rresp;
  assign S_AXI_RDATA   = rdata;

  assign aw_hs  = S_AXI_AWVALID && S_AXI_AWREADY;
  assign w_hs   = S_AXI_WVALID && S_AXI_WREADY;
  assign ar_hs  = S_AXI_ARVALID && S_AXI_ARREADY;
  assign commit = aw_held && w_held && !bvalid;
  assign ar_idx = S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2];
  assign wr_ok  = |wr_hit;

  assign regs_all[0] = DW'(C_ID_VALUE);
  assign regs_all[1] = cnt;
  assign reg_out     = regs_all;

  genvar i;
  generate
    for (i = 0; i < C_NUM_REGS; i++) begin : g_reg
      if (i < 2) begin : g_ro
        assign wr_hit[i]       = 1'b0;
        assign reg_wr_pulse[i] = 1'b0;
      end else begin : g_rw
        localparam logic [IW-1:0] IDX = IW'(i);
        logic [DW-1:0] q;
        logic          pulse_q;
        assign wr_hit[i]       = (aw_idx_q == IDX);
        assign regs_all[i]     = q;
        assign reg_wr_pulse[i] = pulse_q;
        always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
          if (S_AXI_ARESET) begin
            q       <= '0;
            pulse_q <= 1'b0;
          end else begin
            pulse_q <= commit && wr_hit[i];
            if (commit && wr_hit[i])
              for (int b = 0; b < SW; b++)
                if (w_strb_q[b]) q[8*b +: 8] <= w_data_q[8*b +: 8];
          end
        end
      end
    end
  endgenerate

  always_comb begin
    rd_val = '0;
    rd_in  = 1'b0;
    for (int k = 0; k < C_NUM_REGS; k++)
      if (ar_idx == IW'(k)) begin
        rd_val = regs_all[k];
        rd_in  = 1'b1;
      end
  end

  always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
    if (S_AXI_ARESET) begin
      ready_en <= 1'b0;
      cnt      <= '0;
      aw_held  <= 1'b0;
      aw_idx_q <= '0;
      w_held   <= 1'b0;
      w_data_q <= '0;
      w_strb_q <= '0;
      bvalid   <= 1'b0;
      bresp    <= 2'b00;
      rvalid   <= 1'b0;
      rresp    <= 2'b00;
      rdata    <= '0;
    end else begin
      ready_en <= 1'b1;
      cnt      <= cnt + 1'b1;
      if (aw_hs) begin
        aw_held  <= 1'b1;
        aw_idx_q <= S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
      end
      if (w_hs) begin
        w_held   <= 1'b1;
        w_data_q <= S_AXI_WDATA;
        w_strb_q <= S_AXI_WSTRB;
      end
      if (commit) begin
        aw_held <= 1'b0;
        w_held  <= 1'b0;
        bvalid  <= 1'b1;
`ifdef AXIL_REG_SLVERR_EN
        bresp   <= wr_ok ? 2'b00 : 2'b10;
`else
        bresp   <= 2'b00;
`endif
      end else if (bvalid && S_AXI_BREADY) begin
        bvalid  <= 1'b0;
      end
      // rd_val sees pre-commit register state, so a same-edge write is not visible.
      if (ar_hs) begin
        rvalid <= 1'b1;
        rdata  <= rd_val;
`ifdef AXIL_REG_SLVERR_EN
        rresp  <= rd_in ? 2'b00 : 2'b10;
`else
        rresp  <= 2'b00;
`endif
      end else if (rvalid && S_AXI_RREADY) begin
        rvalid <= 1'b0;
      end
    end
  end
endmodule
